nrisc_mc_control: RTL and testbench

- Multicycle control FSM for the 8-bit nRisc core.
- Sequences fetch / decode / execute / memory / write-back over the shared ALU, PC, IR, register file and the single unified memory port.
- Drives the ALU operand muxes, including selection of the 3-bit sign-extended immediate path.
- Adds a memory request/acknowledge handshake with timeout fault detection.

---
 rtl/nrisc_mc_control_pkg.sv | 44 ++++
 rtl/nrisc_mem_timeout.sv | 35 +++
 rtl/nrisc_mc_control.sv | 189 ++++++++++++++++++
 tb/tb_nrisc_mc_control.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_mc_control_pkg.sv
`default_nettype none
// ============================================================================
// nrisc_mc_control_pkg : shared encodings for the nRisc multicycle control
// Revision: 1.0
// ============================================================================
package nrisc_mc_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_sub  = 3'b001;
  localparam logic [2:0] c_op_addi = 3'b010;
  localparam logic [2:0] c_op_lw   = 3'b011;
  localparam logic [2:0] c_op_sw   = 3'b100;
  localparam logic [2:0] c_op_beq  = 3'b101;
  localparam logic [2:0] c_op_j    = 3'b110;
  localparam logic [2:0] c_op_halt = 3'b111;

  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_sub   = 2'b01;
  localparam logic [1:0] c_alu_passb = 2'b10;

  localparam logic [1:0] c_srcb_reg = 2'b00;
  localparam logic [1:0] c_srcb_one = 2'b01;
  localparam logic [1:0] c_srcb_imm = 2'b10;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_target = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  function automatic logic [2:0] opcode_of(input logic [7:0] instr);
    return instr[7:5];
  endfunction

endpackage
`default_nettype wire

// File: rtl/nrisc_mem_timeout.sv
`default_nettype none
// ============================================================================
// nrisc_mem_timeout : wait-cycle counter for the memory handshake
// Revision: 1.0
// ============================================================================
module nrisc_mem_timeout #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] c_last = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Fires during the MEM_TIMEOUT-th consecutive waiting cycle.
  assign o_expired = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/nrisc_mc_control.sv
`default_nettype none
// ============================================================================
// nrisc_mc_control : multicycle control FSM for the 8-bit nRisc core
// Revision: 1.0
// ============================================================================
module nrisc_mc_control
  import nrisc_mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic [7:0] i_instr,
  input  logic       i_alu_zero,
  input  logic       i_mem_ack,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_target_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_halted,
  output logic       o_fault,
  output logic [2:0] o_state
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_op;
  logic       w_expired;
  logic       w_clr;
  logic       w_wait;
  logic       w_unused;

  logic       w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write;
  logic       w_target_write, w_alu_src_a, w_reg_write, w_mem_to_reg;
  logic       w_halted, w_fault;
  logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;

  assign w_op     = opcode_of(i_instr);
  assign w_unused = ^i_instr[4:0];

  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_iord         = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = c_pcsrc_alu;
    w_target_write = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = c_srcb_reg;
    w_alu_op       = c_alu_add;
    w_reg_write    = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_halted       = 1'b0;
    w_fault        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (i_run) begin
          w_mem_req   = 1'b1;
          w_alu_src_b = c_srcb_one;
          if (i_mem_ack) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        // ALUOut captures PC + 1 + sext(imm3) for a possible branch.
        w_alu_src_b    = c_srcb_imm;
        w_target_write = 1'b1;
        if (w_op == c_op_j) begin
          w_pc_write = 1'b1;
          w_pc_src   = c_pcsrc_jump;
        end
      end
      ST_EXEC: begin
        w_alu_src_a = 1'b1;
        case (w_op)
          c_op_add: ;
          c_op_sub: w_alu_op = c_alu_sub;
          c_op_addi, c_op_lw, c_op_sw: begin
            w_alu_src_b    = c_srcb_imm;
            w_target_write = 1'b1;
          end
          c_op_beq: begin
            w_alu_op   = c_alu_sub;
            w_pc_write = i_alu_zero;
            w_pc_src   = c_pcsrc_target;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (w_op == c_op_sw);
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_op == c_op_lw);
      end
      ST_HALT:  w_halted = 1'b1;
      ST_FAULT: w_fault  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (i_run) begin
          if (i_mem_ack)      w_next = ST_DECODE;
          else if (w_expired) w_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (w_op)
          c_op_halt: w_next = ST_HALT;
          c_op_j:    w_next = ST_FETCH;
          default:   w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (w_op)
          c_op_add, c_op_sub, c_op_addi: w_next = ST_WB;
          c_op_lw, c_op_sw:              w_next = ST_MEM;
          default:                       w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (i_mem_ack)      w_next = (w_op == c_op_sw) ? ST_FETCH : ST_WB;
        else if (w_expired) w_next = ST_FAULT;
      end
      ST_WB:    w_next = ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  assign w_wait = w_mem_req & ~i_mem_ack;
  assign w_clr  = i_mem_ack | (w_next != r_state);

  nrisc_mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_wait),
    .o_expired (w_expired)
  );

  // Gating by rst_n kills strobes the instant reset is asserted mid-access.
  assign o_mem_req      = rst_n & w_mem_req;
  assign o_mem_we       = rst_n & w_mem_we;
  assign o_iord         = rst_n & w_iord;
  assign o_ir_write     = rst_n & w_ir_write;
  assign o_pc_write     = rst_n & w_pc_write;
  assign o_pc_src       = rst_n ? w_pc_src : 2'b00;
  assign o_target_write = rst_n & w_target_write;
  assign o_alu_src_a    = rst_n & w_alu_src_a;
  assign o_alu_src_b    = rst_n ? w_alu_src_b : 2'b00;
  assign o_alu_op       = rst_n ? w_alu_op : 2'b00;
  assign o_reg_write    = rst_n & w_reg_write;
  assign o_mem_to_reg   = rst_n & w_mem_to_reg;
  assign o_halted       = rst_n & w_halted;
  assign o_fault        = rst_n & w_fault;
  assign o_state        = rst_n ? r_state : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_nrisc_mc_control.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for nrisc_mc_control: instruction-level model plus directed vectors.
module tb_nrisc_mc_control;

  localparam int TO = 4;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_ADDI = 2, OP_LW = 3;
  localparam int OP_SW = 4, OP_BEQ = 5, OP_J = 6, OP_HALT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write;
  logic [1:0] o_pc_src, o_alu_src_b, o_alu_op;
  logic       o_target_write, o_alu_src_a, o_reg_write, o_mem_to_reg;
  logic       o_halted, o_fault;
  logic [2:0] o_state;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  nrisc_mc_control #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_instr(instr),
    .i_alu_zero(alu_zero), .i_mem_ack(mem_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_iord(o_iord),
    .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
    .o_target_write(o_target_write), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_halted(o_halted), .o_fault(o_fault),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Model: a queue of stages still to visit for the current instruction.
  int m_q[$];
  int m_wait = 0;
  bit m_halt = 1'b0;
  bit m_fault = 1'b0;

  function automatic int cur_stage();
    if (m_fault) return 6;
    if (m_halt) return 5;
    if (m_q.size() == 0) return 0;
    return m_q[0];
  endfunction

  task automatic mem_wait_step();
    if (m_wait + 1 >= TO) m_fault = 1'b1;
    else m_wait++;
  endtask

  task automatic model_step();
    int s;
    int op;
    s  = cur_stage();
    op = int'(instr[7:5]);
    if (s == 0) begin
      if (run) begin
        if (mem_ack) begin
          m_wait = 0;
          case (op)
            OP_ADD, OP_SUB, OP_ADDI: m_q = '{1, 2, 4};
            OP_LW:                   m_q = '{1, 2, 3, 4};
            OP_SW:                   m_q = '{1, 2, 3};
            OP_BEQ:                  m_q = '{1, 2};
            default:                 m_q = '{1};
          endcase
        end else mem_wait_step();
      end
    end else if (s == 3) begin
      if (mem_ack) begin
        void'(m_q.pop_front());
        m_wait = 0;
      end else mem_wait_step();
    end else if (s == 1 && op == OP_HALT) begin
      m_halt = 1'b1;
      m_q.delete();
    end else if (s != 5 && s != 6) begin
      void'(m_q.pop_front());
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wait  = 0;
      m_halt  = 1'b0;
      m_fault = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [19:0] exp_vec();
    logic req, we, iord, irw, pcw, tw, a, rw, m2r, hl, ft;
    logic [1:0] pcs, b, aop;
    int s;
    int op;
    {req, we, iord, irw, pcw, tw, a, rw, m2r, hl, ft} = '0;
    pcs = 2'd0; b = 2'd0; aop = 2'd0;
    if (!rst_n) return 20'd0;
    s  = cur_stage();
    op = int'(instr[7:5]);
    case (s)
      0: if (run) begin
           req = 1; b = 2'd1;
           if (mem_ack) begin irw = 1; pcw = 1; end
         end
      1: begin
           b = 2'd2; tw = 1;
           if (op == OP_J) begin pcw = 1; pcs = 2'd2; end
         end
      2: begin
           a = 1;
           if (op == OP_SUB) aop = 2'd1;
           if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin b = 2'd2; tw = 1; end
           if (op == OP_BEQ) begin aop = 2'd1; pcw = alu_zero; pcs = 2'd1; end
         end
      3: begin req = 1; iord = 1; we = (op == OP_SW); end
      4: begin rw = 1; m2r = (op == OP_LW); end
      5: hl = 1;
      6: ft = 1;
      default: ;
    endcase
    return {req, we, iord, irw, pcw, pcs, tw, a, b, aop, rw, m2r, hl, ft, 3'(s)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write, o_pc_src,
            o_target_write, o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_write,
            o_mem_to_reg, o_halted, o_fault, o_state};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [19:0] e, d;
      e = exp_vec();
      d = dut_vec();
      n_chk++;
      if (d === e) n_pass++;
      else $display("FAIL model_cmp t=%0t actual=%05h expected=%05h", $time, d, e);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int st[8];
  int addi_exp[5] = '{0, 1, 2, 4, 0};

  initial begin
    chk_en = 1'b1;
    run = 1'b1; mem_ack = 1'b1;
    repeat (2) adv();
    @(negedge clk);
    chk("rst_req", int'(o_mem_req), 0);
    chk("rst_vec", int'(dut_vec()), 0);
    adv();
    rst_n = 1'b1; run = 1'b0; mem_ack = 1'b0;
    adv();

    // ADDI +3 with immediate ack
    instr = 8'b010_00_011; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run = (i < 4);
      @(negedge clk);
      st[i] = int'(o_state);
      if (i == 2) chk("addi_exec_srcb", int'(o_alu_src_b), 2);
      if (i == 3) begin
        chk("addi_wb_regw", int'(o_reg_write), 1);
        chk("addi_wb_m2r", int'(o_mem_to_reg), 0);
      end
      adv();
    end
    for (int i = 0; i < 5; i++) chk($sformatf("addi_st%0d", i), st[i], addi_exp[i]);

    // BEQ -2, taken then not taken
    instr = 8'b101_00_110;
    for (int z = 1; z >= 0; z--) begin
      alu_zero = z[0];
      for (int i = 0; i < 4; i++) begin
        run = (i < 3);
        @(negedge clk);
        if (i == 2) begin
          chk($sformatf("beq%0d_pcw", z), int'(o_pc_write), z);
          chk($sformatf("beq%0d_pcsrc", z), int'(o_pc_src), 1);
        end
        if (i == 3) chk($sformatf("beq%0d_back", z), int'(o_state), 0);
        adv();
      end
    end
    alu_zero = 1'b0;

    // LW with ack arriving in the third MEM cycle
    instr = 8'b011_00_001;
    for (int i = 0; i < 8; i++) begin
      run = (i < 7);
      mem_ack = !(i == 3 || i == 4);
      @(negedge clk);
      if (i >= 3 && i <= 5) chk($sformatf("lw_mem%0d", i), int'({o_mem_req, o_iord, o_state}), 'b11_011);
      if (i == 6) chk("lw_wb", int'({o_state, o_mem_to_reg}), 'b100_1);
      adv();
    end

    // SW: no WB
    instr = 8'b100_00_010; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run = (i < 4);
      @(negedge clk);
      if (i == 3) chk("sw_we", int'({o_mem_we, o_state}), 'b1_011);
      if (i == 4) chk("sw_nowb", int'(o_state), 0);
      adv();
    end

    // Fetch timeout: four waiting cycles then sticky FAULT
    instr = 8'b010_00_001; run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i >= 5) begin run = i[0]; mem_ack = ~i[0]; end
      @(negedge clk);
      if (i == 3) chk("to_wait4", int'({o_mem_req, o_state}), 'b1_000);
      if (i >= 4) chk($sformatf("to_fault%0d", i), int'({o_fault, o_state}), 'b1_110);
      adv();
    end
    rst_n = 1'b0; run = 1'b1; mem_ack = 1'b0;
    adv();
    rst_n = 1'b1;

    // Same stimulus, ack in the fourth waiting cycle
    for (int i = 0; i < 8; i++) begin
      run = (i < 7);
      mem_ack = (i >= 3);
      @(negedge clk);
      if (i == 4) chk("to_ackwins", int'({o_fault, o_state}), 'b0_001);
      adv();
    end

    // HALT is terminal until reset
    instr = 8'b111_01_101; run = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) begin run = i[0]; mem_ack = ~i[0]; end
      @(negedge clk);
      if (i == 1) chk("halt_dec", int'(o_halted), 0);
      if (i >= 2) chk($sformatf("halt_h%0d", i), int'({o_halted, o_state}), 'b1_101);
      adv();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("halt_rst", int'({o_halted, o_state}), 0);
    adv();
    rst_n = 1'b1;

    // Reset asserted mid-MEM of a store
    instr = 8'b100_00_011; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i < 3);
      @(negedge clk);
      if (i == 3) chk("swrst_pre", int'({o_mem_req, o_mem_we}), 3);
      if (i < 3) adv();
    end
    #2;
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0;
    #1;
    chk("swrst_drop", int'({o_mem_req, o_mem_we}), 0);
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_vec%0d", i), int'(dut_vec()), 0);
      adv();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
